rain_window_ctrl: RTL and testbench
===================================

Name: rain_window_ctrl

Overview:
- Downstream consumer of the rain module's rain_alarm output.
- Drives a window/skylight motor: closes the window when rain is detected, and auto-reopens it after a sustained dry period if rain closed it.
- Honours manual open/close requests, supervises limit switches and motor run time, and latches a fault on timeout or inconsistent switches.

Parameters:
- MOTOR_TIMEOUT, 16: max cycles the motor may run in one direction before fault.
- DRY_CYCLES, 8: consecutive rain_alarm=0 cycles required before auto-reopen.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rain_alarm  input  1  from rain module; 1 = raining.
- manual_open  input  1  user open request, level, sampled each cycle.
- manual_close  input  1  user close request, level, sampled each cycle.
- limit_open  input  1  window fully open switch.
- limit_closed  input  1  window fully closed switch.
- motor_open  output  1  drive motor in open direction.
- motor_close  output  1  drive motor in close direction.
- window_closed  output  1  1 while in CLOSED.
- fault  output  1  1 while in FAULT.

Behaviour:
- Moore FSM; all outputs decoded from registered state.
- An input sampled at edge N changes state at edge N; the output is visible after edge N.
- States are INIT, OPEN, CLOSING, CLOSED, OPENING, FAULT.
- Reset (asynchronous):
  - state=INIT; all outputs 0; run_cnt=0; dry_cnt=0; auto_flag=0.
  - Reset mid-motion stops the motor immediately.
- INIT, one cycle:
  - limit_closed -> CLOSED.
  - else limit_open -> OPEN.
  - else -> CLOSING (safe default, auto_flag=0).
- OPEN:
  - rain_alarm=1 -> CLOSING, auto_flag=1.
  - else manual_close=1 -> CLOSING, auto_flag=0.
  - manual_open ignored.
- CLOSING:
  - limit_closed=1 -> CLOSED.
  - else run_cnt==MOTOR_TIMEOUT-1 -> FAULT.
  - manual requests ignored.
- CLOSED:
  - manual_open=1 and rain_alarm=0 -> OPENING, auto_flag=0.
  - else dry_cnt==DRY_CYCLES-1 and rain_alarm=0 and auto_flag=1 -> OPENING.
  - manual_open while rain_alarm=1 is ignored.
- OPENING:
  - rain_alarm=1 -> CLOSING, auto_flag=1 (reversal).
  - else manual_close=1 -> CLOSING, auto_flag=0.
  - else limit_open=1 -> OPEN.
  - else run_cnt==MOTOR_TIMEOUT-1 -> FAULT.
- FAULT:
  - Sticky; both motor outputs 0.
  - Exit only via rst.
- Switch consistency: limit_open=1 and limit_closed=1 together in any state except INIT/FAULT -> FAULT. This check takes priority over all other transitions.
- run_cnt:
  - Cleared on every state change, including a CLOSING<->OPENING reversal.
  - Increments each cycle in CLOSING/OPENING.
  - Width $clog2(MOTOR_TIMEOUT)+1.
  - The motor therefore runs at most MOTOR_TIMEOUT cycles.
  - A limit switch seen on the timeout edge wins; no fault.
- dry_cnt:
  - Increments only in CLOSED with rain_alarm=0, saturating at DRY_CYCLES-1.
  - Cleared when rain_alarm=1 or when state is not CLOSED.
- Invariant: motor_open and motor_close are never 1 simultaneously.
- Simultaneous manual_open and manual_close: close wins in OPEN/OPENING; open is evaluated in CLOSED.

Test Plan:
- Params MOTOR_TIMEOUT=8, DRY_CYCLES=4.
- Reset with limit_open=1, then rain_alarm=1 -> after 1 INIT cycle state OPEN; next edge motor_close=1. Assert limit_closed 3 cycles later -> motor_close=0, window_closed=1.
- From CLOSED with auto_flag=1: drop rain_alarm for 4 cycles -> motor_open=1 after the 4th edge. With a rain_alarm=1 pulse at dry cycle 3 -> counter restarts; no open until 4 fresh dry cycles.
- In OPENING, pulse rain_alarm=1 -> next edge motor_open=0, motor_close=1; run_cnt restarts (fault only after 8 more cycles without limit_closed).
- In CLOSING, hold limit_closed=0 -> motor_close=1 for exactly 8 cycles, then fault=1, both motors 0. fault stays 1 despite manual_open; rst clears it to INIT.
- In OPEN, force limit_open=limit_closed=1 -> fault=1 on next edge.
- Assert rst mid-OPENING -> motor_open=0 immediately, without a clock edge.
- Manual path: manual_open=1 in CLOSED with rain_alarm=0 -> OPENING with auto_flag=0; after limit_open -> OPEN and no auto behaviour. manual_open with rain_alarm=1 -> stays CLOSED.

Source files
------------

// File: rtl/rain_window_ctrl.sv
// Window motor controller: closes on rain, reopens after a dry spell only if rain closed it.
// Moore outputs change one edge after the sampled input; no backpressure, inputs are levels.
module rain_window_ctrl #(
    parameter int MOTOR_TIMEOUT = 16,
    parameter int DRY_CYCLES    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rain_alarm,
    input  logic manual_open,
    input  logic manual_close,
    input  logic limit_open,
    input  logic limit_closed,
    output logic motor_open,
    output logic motor_close,
    output logic window_closed,
    output logic fault
);
    localparam int RW = $clog2(MOTOR_TIMEOUT) + 1;
    localparam int DW = $clog2(DRY_CYCLES) + 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(MOTOR_TIMEOUT - 1);
    localparam logic [DW-1:0] DRY_LAST = DW'(DRY_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT,
        OPEN,
        CLOSING,
        CLOSED,
        OPENING,
        FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] run_cnt, run_cnt_nxt;
    logic [DW-1:0] dry_cnt, dry_cnt_nxt;
    logic          auto_flag, auto_flag_nxt;

    logic limits_bad;
    logic run_last;
    logic dry_done;
    logic moving;

    assign limits_bad = limit_open && limit_closed;
    assign run_last   = (run_cnt == RUN_LAST);
    assign dry_done   = (dry_cnt == DRY_LAST) && !rain_alarm && auto_flag;
    assign moving     = (state == CLOSING) || (state == OPENING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            run_cnt   <= '0;
            dry_cnt   <= '0;
            auto_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= run_cnt_nxt;
            dry_cnt   <= dry_cnt_nxt;
            auto_flag <= auto_flag_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        auto_flag_nxt = auto_flag;
        // Both limit switches closed means wiring or switch failure; it outranks every other decision.
        if (limits_bad && state != INIT && state != FAULT) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                INIT: begin
                    if (limit_closed) begin
                        state_nxt = CLOSED;
                    end else if (limit_open) begin
                        state_nxt = OPEN;
                    end else begin
                        state_nxt     = CLOSING;
                        auto_flag_nxt = 1'b0;
                    end
                end
                OPEN: begin
                    if (rain_alarm) begin
                        state_nxt     = CLOSING;
                        auto_flag_nxt = 1'b1;
                    end else if (manual_close) begin
                        state_nxt     = CLOSING;
                        auto_flag_nxt = 1'b0;
                    end
                end
                CLOSING: begin
                    if (limit_closed) begin
                        state_nxt = CLOSED;
                    end else if (run_last) begin
                        state_nxt = FAULT;
                    end
                end
                CLOSED: begin
                    if (manual_open && !rain_alarm) begin
                        state_nxt     = OPENING;
                        auto_flag_nxt = 1'b0;
                    end else if (dry_done) begin
                        state_nxt = OPENING;
                    end
                end
                OPENING: begin
                    if (rain_alarm) begin
                        state_nxt     = CLOSING;
                        auto_flag_nxt = 1'b1;
                    end else if (manual_close) begin
                        state_nxt     = CLOSING;
                        auto_flag_nxt = 1'b0;
                    end else if (limit_open) begin
                        state_nxt = OPEN;
                    end else if (run_last) begin
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = FAULT;
                end
            endcase
        end
    end

    // Run time restarts on any state change, so a reversal gets a full motor budget.
    always_comb begin
        run_cnt_nxt = '0;
        if (moving && state_nxt == state) begin
            run_cnt_nxt = run_cnt + RW'(1);
        end
    end

    always_comb begin
        dry_cnt_nxt = '0;
        if (state == CLOSED && !rain_alarm) begin
            dry_cnt_nxt = (dry_cnt == DRY_LAST) ? dry_cnt : dry_cnt + DW'(1);
        end
    end

    assign motor_open    = (state == OPENING);
    assign motor_close   = (state == CLOSING);
    assign window_closed = (state == CLOSED);
    assign fault         = (state == FAULT);

endmodule

// File: tb/tb_rain_window_ctrl.sv
// Scoreboard bench: driver pushes expected outputs from a behavioural model, monitor pops and compares.
module tb_rain_window_ctrl;
    localparam int MT = 8;
    localparam int DC = 4;

    localparam int M_INIT    = 0;
    localparam int M_OPEN    = 1;
    localparam int M_CLOSING = 2;
    localparam int M_CLOSED  = 3;
    localparam int M_OPENING = 4;
    localparam int M_FAULT   = 5;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic rain_alarm   = 1'b0;
    logic manual_open  = 1'b0;
    logic manual_close = 1'b0;
    logic limit_open   = 1'b0;
    logic limit_closed = 1'b0;
    logic motor_open;
    logic motor_close;
    logic window_closed;
    logic fault;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    // Reference: mode, edges spent in the current mode, length of the current dry streak while closed.
    int m_mode    = M_INIT;
    int m_elapsed = 0;
    int m_dry     = 0;
    bit m_auto    = 0;

    always #5 clk = ~clk;

    rain_window_ctrl #(
        .MOTOR_TIMEOUT(MT),
        .DRY_CYCLES   (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rain_alarm   (rain_alarm),
        .manual_open  (manual_open),
        .manual_close (manual_close),
        .limit_open   (limit_open),
        .limit_closed (limit_closed),
        .motor_open   (motor_open),
        .motor_close  (motor_close),
        .window_closed(window_closed),
        .fault        (fault)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%b required=%b (open,close,closed,fault)", name, $time, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    function automatic logic [3:0] model_out();
        return {m_mode == M_OPENING, m_mode == M_CLOSING, m_mode == M_CLOSED, m_mode == M_FAULT};
    endfunction

    task automatic model_edge();
        int nm;
        nm = m_mode;
        if (m_mode == M_INIT) begin
            if (limit_closed)      nm = M_CLOSED;
            else if (limit_open)   nm = M_OPEN;
            else begin nm = M_CLOSING; m_auto = 0; end
        end else if (m_mode != M_FAULT && limit_open && limit_closed) begin
            nm = M_FAULT;
        end else begin
            case (m_mode)
                M_OPEN: begin
                    if (rain_alarm)        begin nm = M_CLOSING; m_auto = 1; end
                    else if (manual_close) begin nm = M_CLOSING; m_auto = 0; end
                end
                M_CLOSING: begin
                    if (limit_closed)             nm = M_CLOSED;
                    else if (m_elapsed + 1 >= MT) nm = M_FAULT;
                end
                M_CLOSED: begin
                    if (manual_open && !rain_alarm) begin nm = M_OPENING; m_auto = 0; end
                    else if (!rain_alarm && m_auto && m_dry + 1 >= DC) nm = M_OPENING;
                end
                M_OPENING: begin
                    if (rain_alarm)               begin nm = M_CLOSING; m_auto = 1; end
                    else if (manual_close)        begin nm = M_CLOSING; m_auto = 0; end
                    else if (limit_open)          nm = M_OPEN;
                    else if (m_elapsed + 1 >= MT) nm = M_FAULT;
                end
                default: ;
            endcase
        end
        m_dry     = (m_mode == M_CLOSED && !rain_alarm) ? m_dry + 1 : 0;
        m_elapsed = (nm == m_mode) ? m_elapsed + 1 : 0;
        m_mode    = nm;
    endtask

    // Called just after a falling edge; the inputs stay stable across the next rising edge.
    task automatic step(input bit r, input bit mo, input bit mc, input bit lo, input bit lc);
        rain_alarm   = r;
        manual_open  = mo;
        manual_close = mc;
        limit_open   = lo;
        limit_closed = lc;
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic do_reset(input bit lo, input bit lc);
        rst          = 1'b1;
        rain_alarm   = 1'b0;
        manual_open  = 1'b0;
        manual_close = 1'b0;
        limit_open   = lo;
        limit_closed = lc;
        #1;
        check("async_reset", {motor_open, motor_close, window_closed, fault}, 4'b0000);
        m_mode    = M_INIT;
        m_elapsed = 0;
        m_dry     = 0;
        m_auto    = 0;
        @(posedge clk);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            logic [3:0] e;
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {motor_open, motor_close, window_closed, fault}, e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog at %0t: actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit r;
        int k;

        // Rain closes an open window, limit_closed ends the run.
        do_reset(1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Dry streak broken at its third cycle, then four fresh dry cycles reopen.
        repeat (3) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // Rain reversal while opening, then a full timeout, then sticky fault.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (MT) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);

        // Inconsistent limit switches while open.
        do_reset(1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Manually closed window never auto-reopens; rain blocks manual open; reset mid-opening.
        do_reset(0, 1);
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        do_reset(0, 0);

        // Manual open to OPEN, then both manual requests: close wins once open.
        do_reset(0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        for (int round = 0; round < 30; round++) begin
            do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            r = 1'($urandom_range(0, 1));
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 7) == 0) r = !r;
                k = int'($urandom_range(0, 99));
                step(r, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                     (k < 12) || (k == 24), (k >= 12 && k < 25));
            end
        end

        repeat (2) @(posedge clk);
        #3;
        check_int("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
